controller: RTL and testbench
=============================

# controller

Instruction-sequencing stage that sits directly upstream of the accumulator datapath. It owns the 10-bit program counter and fetches 16-bit instructions from a synchronous instruction memory. It decodes each instruction and drives the datapath's mux selects, accumulator enable, ALU opcode, operand and data-memory write strobe. It consumes the datapath's registered N/Z flags and its 10-bit branch target.

## Interface
- DATA_WIDTH, 16, instruction word width
- OPERAND_WIDTH, 11, operand field width (IR[10:0])
- ADDRROM_WIDTH, 10, program counter / instruction address width
- SEL_OPERATION, 3, ALU opcode width
- SEL_WIDTH, 2, accumulator-input mux select width
- Clocking and reset:
  - Single clock `clock_i`, rising edge.
  - `nreset_i` is asynchronous and active-low.
- clock_i  in  1  system clock
- nreset_i  in  1  asynchronous active-low reset
- im_data_i  in  16  instruction memory read data; valid one cycle after im_addr_o
- n_i  in  1  negative flag from datapath (registered there)
- z_i  in  1  zero flag from datapath (registered there)
- ext2pc_i  in  10  branch/jump target from datapath, derived from operand_o
- im_addr_o  out  10  instruction address (= PC)
- selA_o  out  2  accumulator input select: 00 mem data, 01 extended operand, 10 ALU result
- selB_o  out  1  ALU B select: 0 mem data, 1 extended operand
- wrAccA_o  out  1  accumulator write enable
- op_o  out  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
- operand_o  out  11  IR[10:0]; also the data-memory address
- dm_wr_o  out  1  data-memory write strobe (writes accumulator to mem[operand_o])
- halt_o  out  1  high while halted

## Operation
- Instruction format: opcode = IR[15:11], operand = IR[10:0].
- FSM states: FETCH, LATCH, EXEC, WB, HALT.
  - FETCH → LATCH.
  - LATCH: IR <= im_data_i; PC <= PC+1 (10-bit wrap, 1023 → 0); then → EXEC.
  - EXEC → WB for memory-read ops.
  - EXEC → HALT for HLT.
  - EXEC → FETCH otherwise.
  - WB → FETCH.
  - HALT is sticky until reset.
- Default outputs in every state: selA_o=00, selB_o=0, op_o=000, wrAccA_o=0, dm_wr_o=0.
- operand_o = IR[10:0] at all times.
- Opcodes (unlisted opcodes execute as NOP):
  - 00000 NOP.
  - 00001 HLT.
  - 00010 STO: dm_wr_o=1 in EXEC.
  - 00011 LD: selA=00, wrAccA=1 in WB.
  - 00100 LDI: selA=01, wrAccA=1 in EXEC.
  - ALU memory forms: ADD 00101, SUB 00111, AND 01001, OR 01011, XOR 01101. selA=10, selB=0, op per table, wrAccA=1 in WB.
  - ALU immediate forms: ADDI 00110, SUBI 01000, ANDI 01010, ORI 01100, XORI 01110. selA=10, selB=1, op per table, wrAccA=1 in EXEC.
  - 01111 JMP: PC <= ext2pc_i at end of EXEC.
  - Conditional branches, taken condition per opcode:
    - 10000 BEQ: z.
    - 10001 BNE: !z.
    - 10010 BLT: n.
    - 10011 BGE: !n.
    - 10100 BGT: !n & !z.
    - 10101 BLE: n | z.
    - Taken: PC <= ext2pc_i at end of EXEC.
    - Not taken: PC keeps the incremented value.
- In WB, selA/selB/op hold the values of the memory-read instruction (mem data valid that cycle).

## Timing
- Reset (asynchronous, any state, mid-instruction included):
  - State=FETCH, PC=0, IR=0.
  - All outputs 0: im_addr_o=0, operand_o=0, halt_o=0.
- First fetch uses address 0 on the first edge after nreset_i deasserts.
- Cycles per instruction:
  - 3 for NOP, STO, LDI, ALU-immediate, JMP and branches.
  - 4 for LD and ALU-memory ops.
  - HLT enters HALT after 3 cycles.
- Memory timing:
  - Instruction memory and data memory both have 1-cycle synchronous read latency.
  - operand_o is stable from the LATCH edge through EXEC and WB, so the data-memory read issued in EXEC returns in WB.
- Flag timing:
  - Datapath flags update one edge after the accumulator write.
  - A branch's EXEC always falls ≥2 edges after the preceding instruction's accumulator write, so n_i/z_i are valid; no extra stall is required.
- Store timing:
  - dm_wr_o is a single-cycle pulse, asserted only in EXEC.
  - STO immediately after a write to the accumulator stores the new value.
- Jump/branch timing:
  - A taken branch or JMP is visible on im_addr_o in the FETCH that follows.
  - A branch at PC 1023 that is not taken continues at PC 0.
- HALT: halt_o=1, PC frozen, no writes.

## Test plan
- Reset mid-EXEC of ADDI → all outputs 0 immediately (asynchronous); after release, im_addr_o=0 and the first FETCH occurs.
- Program LDI 5; ADDI 3; STO 7; HLT → wrAccA pulses in EXEC with selA=01, then selA=10/selB=1/op=000; dm_wr_o pulses once with operand_o=7; halt_o=1 after 12 cycles; PC=4.
- LD 10 with mem[10]=0x8000, then BLT 0x020 → WB writes with selA=00; branch taken (n_i=1); next im_addr_o=0x020.
- SUBI 0 with acc=0, then BNE 0x100 → not taken; BEQ 0x100 → taken; im_addr_o=0x100 in the following FETCH.
- Illegal opcode 11111 → behaves as NOP; 3 cycles, no strobes, PC+1.
- NOP at address 1023 → PC wraps to 0; JMP 0x3FF → PC=1023.

Source files
------------

// File: rtl/controller_if.sv
// Controller <-> instruction memory / accumulator datapath bundle.
// master = controller side, slave = memory/datapath side.
interface controller_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int ADDRROM_WIDTH = 10,
  parameter int SEL_OPERATION = 3,
  parameter int SEL_WIDTH     = 2
);
  logic [DATA_WIDTH-1:0]    im_data_i;
  logic                     n_i;
  logic                     z_i;
  logic [ADDRROM_WIDTH-1:0] ext2pc_i;
  logic [ADDRROM_WIDTH-1:0] im_addr_o;
  logic [SEL_WIDTH-1:0]     selA_o;
  logic                     selB_o;
  logic                     wrAccA_o;
  logic [SEL_OPERATION-1:0] op_o;
  logic [OPERAND_WIDTH-1:0] operand_o;
  logic                     dm_wr_o;
  logic                     halt_o;

  modport master (
    input  im_data_i, n_i, z_i, ext2pc_i,
    output im_addr_o, selA_o, selB_o, wrAccA_o, op_o, operand_o, dm_wr_o, halt_o
  );

  modport slave (
    output im_data_i, n_i, z_i, ext2pc_i,
    input  im_addr_o, selA_o, selB_o, wrAccA_o, op_o, operand_o, dm_wr_o, halt_o
  );
endinterface

// File: rtl/controller.sv
// Instruction sequencer for the accumulator datapath: owns PC and IR, fetches
// from a 1-cycle synchronous instruction memory and decodes into datapath controls.
//
// state | meaning
// FETCH | im_addr_o = PC presented to instruction memory
// LATCH | instruction word arrives; IR captured, PC incremented
// EXEC  | decoded controls driven; jumps/branches redirect PC
// WB    | data-memory read returns; accumulator written (LD, ALU-memory ops)
// HALT  | sticky until reset; no writes, PC frozen
module controller #(
  parameter int DATA_WIDTH    = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int ADDRROM_WIDTH = 10,
  parameter int SEL_OPERATION = 3,
  parameter int SEL_WIDTH     = 2
) (
  input  logic          clock_i,
  input  logic          nreset_i,
  controller_if.master  bus
);

  localparam int OPC_WIDTH = DATA_WIDTH - OPERAND_WIDTH;

  localparam logic [OPC_WIDTH-1:0] OPC_HLT  = 5'b00001;
  localparam logic [OPC_WIDTH-1:0] OPC_STO  = 5'b00010;
  localparam logic [OPC_WIDTH-1:0] OPC_LD   = 5'b00011;
  localparam logic [OPC_WIDTH-1:0] OPC_LDI  = 5'b00100;
  localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00101;
  localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 5'b00110;
  localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00111;
  localparam logic [OPC_WIDTH-1:0] OPC_SUBI = 5'b01000;
  localparam logic [OPC_WIDTH-1:0] OPC_AND  = 5'b01001;
  localparam logic [OPC_WIDTH-1:0] OPC_ANDI = 5'b01010;
  localparam logic [OPC_WIDTH-1:0] OPC_OR   = 5'b01011;
  localparam logic [OPC_WIDTH-1:0] OPC_ORI  = 5'b01100;
  localparam logic [OPC_WIDTH-1:0] OPC_XOR  = 5'b01101;
  localparam logic [OPC_WIDTH-1:0] OPC_XORI = 5'b01110;
  localparam logic [OPC_WIDTH-1:0] OPC_JMP  = 5'b01111;
  localparam logic [OPC_WIDTH-1:0] OPC_BEQ  = 5'b10000;
  localparam logic [OPC_WIDTH-1:0] OPC_BNE  = 5'b10001;
  localparam logic [OPC_WIDTH-1:0] OPC_BLT  = 5'b10010;
  localparam logic [OPC_WIDTH-1:0] OPC_BGE  = 5'b10011;
  localparam logic [OPC_WIDTH-1:0] OPC_BGT  = 5'b10100;
  localparam logic [OPC_WIDTH-1:0] OPC_BLE  = 5'b10101;

  localparam logic [SEL_OPERATION-1:0] ALU_ADD = 3'b000;
  localparam logic [SEL_OPERATION-1:0] ALU_SUB = 3'b001;
  localparam logic [SEL_OPERATION-1:0] ALU_AND = 3'b010;
  localparam logic [SEL_OPERATION-1:0] ALU_OR  = 3'b011;
  localparam logic [SEL_OPERATION-1:0] ALU_XOR = 3'b100;

  localparam logic [SEL_WIDTH-1:0] SEL_MEM  = 2'b00;
  localparam logic [SEL_WIDTH-1:0] SEL_OPND = 2'b01;
  localparam logic [SEL_WIDTH-1:0] SEL_ALU  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_LATCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRROM_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0]    ir_q, ir_d;

  logic [OPC_WIDTH-1:0]     opc;
  logic [SEL_OPERATION-1:0] alu_op;
  logic                     alu_mem, alu_imm;
  logic                     is_ld, is_ldi, is_sto, is_hlt, is_jmp, br_taken;
  logic                     mem_rd;

  logic [SEL_WIDTH-1:0]     sel_a;
  logic                     sel_b;
  logic [SEL_OPERATION-1:0] op_sel;
  logic                     wr_acc;
  logic                     dm_wr;

  assign opc    = ir_q[DATA_WIDTH-1:OPERAND_WIDTH];
  assign mem_rd = is_ld | alu_mem;

  // Instruction decode is purely a function of IR (plus flags for branches),
  // so it stays stable through EXEC and WB.
  always_comb begin
    alu_op   = ALU_ADD;
    alu_mem  = 1'b0;
    alu_imm  = 1'b0;
    is_ld    = 1'b0;
    is_ldi   = 1'b0;
    is_sto   = 1'b0;
    is_hlt   = 1'b0;
    is_jmp   = 1'b0;
    br_taken = 1'b0;
    case (opc)
      OPC_HLT:  is_hlt = 1'b1;
      OPC_STO:  is_sto = 1'b1;
      OPC_LD:   is_ld  = 1'b1;
      OPC_LDI:  is_ldi = 1'b1;
      OPC_ADD:  begin alu_mem = 1'b1; alu_op = ALU_ADD; end
      OPC_ADDI: begin alu_imm = 1'b1; alu_op = ALU_ADD; end
      OPC_SUB:  begin alu_mem = 1'b1; alu_op = ALU_SUB; end
      OPC_SUBI: begin alu_imm = 1'b1; alu_op = ALU_SUB; end
      OPC_AND:  begin alu_mem = 1'b1; alu_op = ALU_AND; end
      OPC_ANDI: begin alu_imm = 1'b1; alu_op = ALU_AND; end
      OPC_OR:   begin alu_mem = 1'b1; alu_op = ALU_OR;  end
      OPC_ORI:  begin alu_imm = 1'b1; alu_op = ALU_OR;  end
      OPC_XOR:  begin alu_mem = 1'b1; alu_op = ALU_XOR; end
      OPC_XORI: begin alu_imm = 1'b1; alu_op = ALU_XOR; end
      OPC_JMP:  is_jmp = 1'b1;
      OPC_BEQ:  br_taken = bus.z_i;
      OPC_BNE:  br_taken = ~bus.z_i;
      OPC_BLT:  br_taken = bus.n_i;
      OPC_BGE:  br_taken = ~bus.n_i;
      OPC_BGT:  br_taken = ~bus.n_i & ~bus.z_i;
      OPC_BLE:  br_taken = bus.n_i | bus.z_i;
      default:  ;
    endcase
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sel_a   = SEL_MEM;
    sel_b   = 1'b0;
    op_sel  = ALU_ADD;
    wr_acc  = 1'b0;
    dm_wr   = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ir_d    = bus.im_data_i;
        pc_d    = pc_q + ADDRROM_WIDTH'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (is_ldi) begin
          sel_a  = SEL_OPND;
          wr_acc = 1'b1;
        end
        if (alu_imm) begin
          sel_a  = SEL_ALU;
          sel_b  = 1'b1;
          op_sel = alu_op;
          wr_acc = 1'b1;
        end
        dm_wr = is_sto;
        if (is_jmp || br_taken) pc_d = bus.ext2pc_i;
        if (is_hlt)      state_d = S_HALT;
        else if (mem_rd) state_d = S_WB;
        else             state_d = S_FETCH;
      end
      S_WB: begin
        // data-memory read issued during EXEC is valid now
        wr_acc = 1'b1;
        if (alu_mem) begin
          sel_a  = SEL_ALU;
          op_sel = alu_op;
        end
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.im_addr_o = pc_q;
  assign bus.operand_o = ir_q[OPERAND_WIDTH-1:0];
  assign bus.selA_o    = sel_a;
  assign bus.selB_o    = sel_b;
  assign bus.op_o      = op_sel;
  assign bus.wrAccA_o  = wr_acc;
  assign bus.dm_wr_o   = dm_wr;
  assign bus.halt_o    = (state_q == S_HALT);

endmodule

// File: tb/tb_controller.sv
// Bench for controller: memories and accumulator datapath around the DUT, plus
// an instruction-level reference that expands each program into its expected cycle trace.
module tb_controller;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  controller_if bus ();
  controller dut (.clock_i(clk), .nreset_i(nreset), .bus(bus));

  typedef struct packed {
    logic [9:0]  addr;
    logic [1:0]  sela;
    logic        selb;
    logic        wr;
    logic [2:0]  op;
    logic [10:0] opnd;
    logic        dmwr;
    logic        halt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] imem   [0:1023];
  logic [15:0] dmem   [0:2047];
  logic [15:0] m_dmem [0:2047];
  logic [15:0] im_data, dm_rdata, acc, ext, alu_b, alu_y, acc_in;
  logic        n_q, z_q;
  logic        pre_we = 1'b0;
  logic [10:0] pre_addr = '0;
  logic [15:0] pre_data = '0;

  vec_t exp_tr [0:255];
  vec_t obs    [0:255];
  int   ntr;
  vec_t cur;

  assign bus.im_data_i = im_data;
  assign bus.n_i       = n_q;
  assign bus.z_i       = z_q;
  assign bus.ext2pc_i  = bus.operand_o[9:0];
  assign ext           = {{5{bus.operand_o[10]}}, bus.operand_o};
  assign cur = {bus.im_addr_o, bus.selA_o, bus.selB_o, bus.wrAccA_o, bus.op_o,
                bus.operand_o, bus.dm_wr_o, bus.halt_o};

  // accumulator datapath environment
  always_comb begin
    alu_b = bus.selB_o ? ext : dm_rdata;
    case (bus.op_o)
      3'b001:  alu_y = acc - alu_b;
      3'b010:  alu_y = acc & alu_b;
      3'b011:  alu_y = acc | alu_b;
      3'b100:  alu_y = acc ^ alu_b;
      default: alu_y = acc + alu_b;
    endcase
    case (bus.selA_o)
      2'b01:   acc_in = ext;
      2'b10:   acc_in = alu_y;
      default: acc_in = dm_rdata;
    endcase
  end

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc <= '0;
      n_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      if (bus.wrAccA_o) acc <= acc_in;
      n_q <= acc[15];
      z_q <= (acc == 16'h0);
    end
  end

  always @(posedge clk) begin
    im_data  <= imem[bus.im_addr_o];
    dm_rdata <= dmem[bus.operand_o];
    if (pre_we) dmem[pre_addr] <= pre_data;
    else if (bus.dm_wr_o) dmem[bus.operand_o] <= acc;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int opc, input int opnd);
    logic [4:0]  o;
    logic [10:0] a;
    o = 5'(opc);
    a = 11'(opnd);
    return {o, a};
  endfunction

  function automatic vec_t mk(input int addr, input int sela, input int selb, input int wr,
                              input int op, input int opnd, input int dmwr, input int halt);
    vec_t v;
    v.addr = 10'(addr); v.sela = 2'(sela); v.selb = 1'(selb); v.wr = 1'(wr);
    v.op = 3'(op); v.opnd = 11'(opnd); v.dmwr = 1'(dmwr); v.halt = 1'(halt);
    return v;
  endfunction

  function automatic logic [15:0] m_alu(input int k, input logic [15:0] a, input logic [15:0] b);
    case (k)
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      default: return a + b;
    endcase
  endfunction

  task automatic push(input vec_t v);
    exp_tr[ntr] = v;
    ntr++;
  endtask

  // Architectural interpreter: each instruction costs FETCH, LATCH, EXEC (+WB).
  task automatic build_trace();
    int pc = 0;
    int prev_opnd = 0;
    int nins = 0;
    bit halted = 0;
    logic [15:0] a = '0;
    ntr = 0;
    for (int i = 0; i < 2048; i++) m_dmem[i] = dmem[i];
    while (!halted && nins < 40) begin
      logic [15:0] instr, x;
      int opc, opnd, pc1, npc, k, imm;
      bit n, z, t;
      vec_t v, w;
      instr = imem[pc];
      opc   = int'(instr[15:11]);
      opnd  = int'(instr[10:0]);
      x     = {{5{instr[10]}}, instr[10:0]};
      push(mk(pc, 0, 0, 0, 0, prev_opnd, 0, 0));
      push(mk(pc, 0, 0, 0, 0, prev_opnd, 0, 0));
      pc1 = (pc + 1) % 1024;
      npc = pc1;
      v = mk(pc1, 0, 0, 0, 0, opnd, 0, 0);
      w = v;
      w.wr = 1'b1;
      if (opc == 1) halted = 1;
      else if (opc == 2) begin
        v.dmwr = 1'b1;
        m_dmem[opnd] = a;
      end else if (opc == 3) begin
        a = m_dmem[opnd];
      end else if (opc == 4) begin
        v.sela = 2'd1; v.wr = 1'b1;
        a = x;
      end else if (opc >= 5 && opc <= 14) begin
        k   = (opc - 5) / 2;
        imm = (opc - 5) % 2;
        a   = m_alu(k, a, imm ? x : m_dmem[opnd]);
        if (imm == 1) begin
          v.sela = 2'd2; v.selb = 1'b1; v.op = 3'(k); v.wr = 1'b1;
        end else begin
          w.sela = 2'd2; w.op = 3'(k);
        end
      end else if (opc == 15) begin
        npc = opnd % 1024;
      end else if (opc >= 16 && opc <= 21) begin
        n = a[15];
        z = (a == 16'h0);
        case (opc)
          16:      t = z;
          17:      t = !z;
          18:      t = n;
          19:      t = !n;
          20:      t = !n && !z;
          default: t = n || z;
        endcase
        if (t) npc = opnd % 1024;
      end
      push(v);
      if (opc == 3 || (opc >= 5 && opc <= 14 && ((opc - 5) % 2) == 0)) push(w);
      prev_opnd = opnd;
      pc = npc;
      nins++;
    end
    for (int i = 0; i < 4; i++) push(mk(pc, 0, 0, 0, 0, prev_opnd, 0, 1));
  endtask

  task automatic run_prog(input int pid);
    build_trace();
    @(negedge clk);
    nreset = 1'b1;
    #1;
    for (int k = 0; k < ntr; k++) begin
      if (k > 0) @(negedge clk);
      obs[k] = cur;
      check($sformatf("p%0d_cyc%0d", pid, k), {2'b00, cur}, {2'b00, exp_tr[k]});
    end
  endtask

  task automatic start_prog();
    nreset = 1'b0;
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
  endtask

  task automatic poke_dm(input int addr, input logic [15:0] d);
    pre_addr = 11'(addr);
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // asynchronous reset in the middle of an ADDI EXEC
    start_prog();
    imem[0] = enc(6, 3);
    #12;
    @(negedge clk);
    nreset = 1'b1;
    #1 check("rst_fetch_addr", 32'(bus.im_addr_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_exec_wr", 32'(bus.wrAccA_o), 32'h1);
    check("rst_exec_opnd", 32'(bus.operand_o), 32'h3);
    #2 nreset = 1'b0;
    #1 check("rst_async_all", {2'b00, cur}, 32'h0);
    @(negedge clk);
    nreset = 1'b1;
    #1 check("rst_release_addr", 32'(bus.im_addr_o), 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("rst_refetch_opnd", 32'(bus.operand_o), 32'h3);
    check("rst_refetch_addr", 32'(bus.im_addr_o), 32'h1);

    // LDI 5; ADDI 3; STO 7; HLT
    start_prog();
    imem[0] = enc(4, 5); imem[1] = enc(6, 3); imem[2] = enc(2, 7); imem[3] = enc(1, 0);
    run_prog(1);
    check("p1_ldi_exec", {26'h0, obs[2].sela, obs[2].selb, obs[2].wr}, {26'h0, 2'b01, 1'b0, 1'b1});
    check("p1_addi_exec", {25'h0, obs[5].sela, obs[5].selb, obs[5].wr, obs[5].op},
          {25'h0, 2'b10, 1'b1, 1'b1, 3'b000});
    check("p1_sto_pulse", {20'h0, obs[8].dmwr, obs[8].opnd}, {20'h0, 1'b1, 11'd7});
    cnt = 0;
    for (int k = 0; k < ntr; k++) cnt += int'(obs[k].dmwr);
    check("p1_sto_count", 32'(cnt), 32'd1);
    check("p1_not_halt_11", 32'(obs[11].halt), 32'h0);
    check("p1_halt_12", 32'(obs[12].halt), 32'h1);
    check("p1_halt_pc", 32'(obs[12].addr), 32'd4);
    check("p1_mem7", 32'(dmem[7]), 32'h8);

    // LD 10 (mem[10]=0x8000); BLT 0x020
    start_prog();
    imem[0] = enc(3, 10); imem[1] = enc(18, 'h20); imem['h20] = enc(1, 0);
    poke_dm(10, 16'h8000);
    run_prog(2);
    check("p2_ld_exec_wr", 32'(obs[2].wr), 32'h0);
    check("p2_ld_wb", {28'h0, obs[3].sela, obs[3].selb, obs[3].wr}, {28'h0, 2'b00, 1'b0, 1'b1});
    check("p2_blt_target", 32'(obs[7].addr), 32'h20);

    // LDI 0; SUBI 0; BNE 0x100; BEQ 0x100
    start_prog();
    imem[0] = enc(4, 0); imem[1] = enc(8, 0); imem[2] = enc(17, 'h100);
    imem[3] = enc(16, 'h100); imem['h100] = enc(1, 0);
    run_prog(3);
    check("p3_bne_not_taken", 32'(obs[9].addr), 32'd3);
    check("p3_beq_taken", 32'(obs[12].addr), 32'h100);

    // illegal opcode, wrap through 1023
    start_prog();
    imem[0] = enc(31, 'h7FF); imem[1] = enc(16, 'h3FE); imem[2] = enc(1, 0);
    imem[1022] = enc(4, 1); imem[1023] = enc(0, 0);
    run_prog(4);
    check("p4_ill_strobes", {29'h0, obs[2].wr, obs[2].dmwr, 1'b0}, 32'h0);
    check("p4_ill_pc", 32'(obs[3].addr), 32'd1);
    check("p4_beq_taken", 32'(obs[6].addr), 32'h3FE);
    check("p4_nop_1023", 32'(obs[9].addr), 32'h3FF);
    check("p4_wrap", 32'(obs[12].addr), 32'h0);
    check("p4_beq_not_taken", 32'(obs[18].addr), 32'd2);

    // JMP 0x3FF
    start_prog();
    imem[0] = enc(15, 'h3FF); imem[1023] = enc(1, 0);
    run_prog(5);
    check("p5_jmp_target", 32'(obs[3].addr), 32'h3FF);
    check("p5_halt_wrap", {22'h0, obs[6].halt, obs[6].addr}, {22'h0, 1'b1, 10'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
